aes_cbc_chain: RTL and testbench

CBC chaining and word-serial framing stage wrapped around the combinational `aes_en` core. It accepts plaintext as 32-bit words over a valid/ready handshake and packs four words into a 128-bit block. It XORs the block with the chaining value, drives the result into `aes_en.data_in`, and registers `aes_en.data_out`. The ciphertext becomes the next chaining value and is streamed back out as four 32-bit words. The key is not handled here; it is wired directly to `aes_en.key`.

---
 rtl/aes_cbc_chain.sv | 171 +++++++++++++++++
 tb/tb_aes_cbc_chain.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_cbc_chain.sv
// rtl/aes_cbc_chain.sv - CBC chaining and 32-bit word framing around a combinational AES-128 core
module aes_cbc_chain #(
    parameter int LEN_BLOCK = 128,
    parameter int LEN_WORD  = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 iv_load,
    input  logic [LEN_BLOCK-1:0] iv,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [LEN_WORD-1:0]  in_data,
    output logic [LEN_BLOCK-1:0] enc_data,
    input  logic [LEN_BLOCK-1:0] enc_result,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [LEN_WORD-1:0]  out_data,
    output logic                 busy
);

    // Four words per block; the counter is two bits wide and the last index is 3.
    localparam int                 PART_W   = LEN_BLOCK - LEN_WORD;
    localparam logic [1:0]         LAST_IDX = 2'd3;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        ENC     = 2'd1,
        EMIT    = 2'd2
    } state_t;

    state_t               state, state_n;
    logic [1:0]           cnt, cnt_n;
    logic                 in_ready_n;
    logic                 out_valid_n;
    logic [PART_W-1:0]    part_buf;
    logic [LEN_BLOCK-1:0] chain;
    logic [LEN_BLOCK-1:0] result;

    // Datapath strobes decoded by the next-state logic.
    logic                 word_take;
    logic                 block_done;
    logic                 enc_step;
    logic                 in_fire;
    logic                 out_fire;

    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;

    // Control registers: state, word counter, handshake flags and busy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= COLLECT;
            cnt       <= 2'd0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            in_ready  <= in_ready_n;
            out_valid <= out_valid_n;
            busy      <= (state_n != COLLECT);
        end
    end

    // Next-state and strobe decode; iv_load overrides every other event.
    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        in_ready_n  = in_ready;
        out_valid_n = out_valid;
        word_take   = 1'b0;
        block_done  = 1'b0;
        enc_step    = 1'b0;

        if (iv_load) begin
            state_n     = COLLECT;
            cnt_n       = 2'd0;
            in_ready_n  = 1'b1;
            out_valid_n = 1'b0;
        end else begin
            case (state)
                COLLECT: begin
                    // in_ready comes up on the first edge after reset release.
                    in_ready_n  = 1'b1;
                    out_valid_n = 1'b0;
                    if (in_fire) begin
                        word_take = 1'b1;
                        if (cnt == LAST_IDX) begin
                            block_done = 1'b1;
                            cnt_n      = 2'd0;
                            in_ready_n = 1'b0;
                            state_n    = ENC;
                        end else begin
                            cnt_n = cnt + 2'd1;
                        end
                    end
                end
                ENC: begin
                    enc_step    = 1'b1;
                    in_ready_n  = 1'b0;
                    out_valid_n = 1'b1;
                    cnt_n       = 2'd0;
                    state_n     = EMIT;
                end
                EMIT: begin
                    in_ready_n = 1'b0;
                    if (out_fire) begin
                        if (cnt == LAST_IDX) begin
                            cnt_n       = 2'd0;
                            out_valid_n = 1'b0;
                            in_ready_n  = 1'b1;
                            state_n     = COLLECT;
                        end else begin
                            cnt_n = cnt + 2'd1;
                        end
                    end
                end
                default: begin
                    state_n     = COLLECT;
                    cnt_n       = 2'd0;
                    in_ready_n  = 1'b1;
                    out_valid_n = 1'b0;
                end
            endcase
        end
    end

    // Partial block buffer: first three words of a block, oldest in the top bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            part_buf <= '0;
        end else if (word_take && !block_done) begin
            part_buf <= {part_buf[PART_W-LEN_WORD-1:0], in_data};
        end
    end

    // Cipher input register: the completed block XORed with the chaining value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            enc_data <= '0;
        end else if (block_done) begin
            enc_data <= {part_buf, in_data} ^ chain;
        end
    end

    // Chaining value and ciphertext capture; the core output is sampled in ENC.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chain  <= '0;
            result <= '0;
        end else if (iv_load) begin
            chain  <= iv;
        end else if (enc_step) begin
            chain  <= enc_result;
            result <= enc_result;
        end
    end

    // Output word select; word 0 is the most significant 32 bits.
    always_comb begin
        out_data = result[LEN_BLOCK-1 -: LEN_WORD];
        case (cnt)
            2'd0:    out_data = result[LEN_BLOCK-1              -: LEN_WORD];
            2'd1:    out_data = result[LEN_BLOCK-1-LEN_WORD     -: LEN_WORD];
            2'd2:    out_data = result[LEN_BLOCK-1-2*LEN_WORD   -: LEN_WORD];
            default: out_data = result[LEN_BLOCK-1-3*LEN_WORD   -: LEN_WORD];
        endcase
    end

endmodule

// File: tb/tb_aes_cbc_chain.sv
// tb/tb_aes_cbc_chain.sv - scoreboard bench for aes_cbc_chain with a behavioural AES-128 core
module tb_aes_cbc_chain;

    logic         clk;
    logic         rst;
    logic         iv_load;
    logic [127:0] iv;
    logic         in_valid;
    logic         in_ready;
    logic [31:0]  in_data;
    logic [127:0] enc_data;
    logic [127:0] enc_result;
    logic         out_valid;
    logic         out_ready;
    logic [31:0]  out_data;
    logic         busy;

    localparam logic [127:0] KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] PT0 = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CT0 = 128'h3925841d02dc09fbdc118597196a0b32;

    int           n_checks = 0;
    int           n_errors = 0;
    logic [31:0]  sb[$];
    logic [127:0] chain_m;

    aes_cbc_chain #(.LEN_BLOCK(128), .LEN_WORD(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .iv_load    (iv_load),
        .iv         (iv),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .enc_data   (enc_data),
        .enc_result (enc_result),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural AES-128 encryption ----------------
    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xt(x);
        end
        return p;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0]  inv;
        logic [7:0]  base;
        logic [7:0]  e;
        logic [15:0] d;
        inv  = 8'h01;
        base = a;
        e    = 8'd254;
        for (int i = 0; i < 8; i++) begin
            if (e[i]) inv = gmul(inv, base);
            base = gmul(base, base);
        end
        d = {inv, inv};
        return inv ^ d[14:7] ^ d[13:6] ^ d[12:5] ^ d[11:4] ^ 8'h63;
    endfunction

    function automatic logic [127:0] aes128(input logic [127:0] pt, input logic [127:0] key);
        logic [7:0]   s[16];
        logic [7:0]   t[16];
        logic [31:0]  w[4];
        logic [31:0]  tmp;
        logic [7:0]   rc;
        logic [127:0] o;
        for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ key[127-8*i -: 8];
        for (int c = 0; c < 4; c++) w[c] = key[127-32*c -: 32];
        rc = 8'h01;
        for (int r = 1; r <= 10; r++) begin
            tmp  = w[3];
            tmp  = {sbox(tmp[23:16]), sbox(tmp[15:8]), sbox(tmp[7:0]), sbox(tmp[31:24])} ^ {rc, 24'h0};
            w[0] = w[0] ^ tmp;
            w[1] = w[1] ^ w[0];
            w[2] = w[2] ^ w[1];
            w[3] = w[3] ^ w[2];
            rc   = xt(rc);
            for (int c = 0; c < 4; c++)
                for (int rr = 0; rr < 4; rr++)
                    t[rr+4*c] = sbox(s[rr + 4*((c+rr)%4)]);
            if (r != 10) begin
                for (int c = 0; c < 4; c++) begin
                    s[4*c]   = gmul(t[4*c], 8'h02) ^ gmul(t[4*c+1], 8'h03) ^ t[4*c+2] ^ t[4*c+3];
                    s[4*c+1] = t[4*c] ^ gmul(t[4*c+1], 8'h02) ^ gmul(t[4*c+2], 8'h03) ^ t[4*c+3];
                    s[4*c+2] = t[4*c] ^ t[4*c+1] ^ gmul(t[4*c+2], 8'h02) ^ gmul(t[4*c+3], 8'h03);
                    s[4*c+3] = gmul(t[4*c], 8'h03) ^ t[4*c+1] ^ t[4*c+2] ^ gmul(t[4*c+3], 8'h02);
                end
            end else begin
                s = t;
            end
            for (int c = 0; c < 4; c++)
                for (int rr = 0; rr < 4; rr++)
                    s[rr+4*c] = s[rr+4*c] ^ w[c][31-8*rr -: 8];
        end
        for (int i = 0; i < 16; i++) o[127-8*i -: 8] = s[i];
        return o;
    endfunction

    assign enc_result = aes128(enc_data, KEY);

    // ---------------- checking helpers ----------------
    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Output monitor: pops the scoreboard for each handshake and checks hold stability.
    logic [31:0] prev_data;
    logic        prev_stall = 1'b0;
    always @(negedge clk) begin
        #1;
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall && out_valid) chk("hold_stable", out_data, prev_data);
            if (out_valid) chk("in_ready_low_in_emit", in_ready, 1'b0);
            if (out_valid && out_ready) begin
                n_checks++;
                assert (sb.size() != 0) else begin
                    n_errors++;
                    $error("FAIL unexpected_word: observed %h expected none", out_data);
                end
                if (sb.size() != 0) chk("out_word", out_data, sb.pop_front());
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
        end
    end

    task automatic send_words(input logic [127:0] pt, input int n, input bit gaps);
        int  w;
        int  g;
        bit  acc;
        w = 0;
        g = 0;
        while (w < n && g < 200) begin
            in_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            in_data  = pt[127-32*w -: 32];
            acc      = in_valid && in_ready;
            @(negedge clk);
            g++;
            if (acc) w++;
        end
        in_valid = 1'b0;
        chk("accept_count", w, n);
    endtask

    task automatic send_block(input logic [127:0] pt, input bit gaps, input bit use_kat, input logic [127:0] kat);
        logic [127:0] blk;
        logic [127:0] ct;
        send_words(pt, 4, gaps);
        blk = pt ^ chain_m;
        chk("enc_data", enc_data, blk);
        chk("in_ready_low_enc", in_ready, 1'b0);
        chk("busy_enc", busy, 1'b1);
        ct = use_kat ? kat : aes128(blk, KEY);
        chain_m = ct;
        for (int i = 0; i < 4; i++) sb.push_back(ct[127-32*i -: 32]);
    endtask

    task automatic load_iv(input logic [127:0] v, input bit junk);
        iv       = v;
        iv_load  = 1'b1;
        in_valid = junk;
        in_data  = 32'hdeadbeef;
        @(negedge clk);
        iv_load  = 1'b0;
        in_valid = 1'b0;
        chain_m  = v;
        chk("in_ready_after_iv", in_ready, 1'b1);
    endtask

    task automatic wait_out_valid();
        int g;
        g = 0;
        while (!out_valid && g < 50) begin
            @(negedge clk);
            g++;
        end
        chk("out_valid_rise", out_valid, 1'b1);
    endtask

    task automatic drain();
        int g;
        g = 0;
        out_ready = 1'b1;
        while (sb.size() != 0 && g < 100) begin
            @(negedge clk);
            #2;
            g++;
        end
        chk("drain_empty", sb.size(), 0);
        @(negedge clk);
        chk("out_valid_after_block", out_valid, 1'b0);
        chk("in_ready_after_block", in_ready, 1'b1);
        chk("busy_after_block", busy, 1'b0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        logic [127:0] pt;
        logic [127:0] v;
        rst       = 1'b1;
        iv_load   = 1'b0;
        iv        = '0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        chain_m   = '0;

        // Reset values
        repeat (2) @(negedge clk);
        chk("rst_in_ready", in_ready, 1'b0);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_data", out_data, 32'h0);
        chk("rst_enc_data", enc_data, 128'h0);
        chk("rst_busy", busy, 1'b0);
        rst = 1'b0;
        chk("in_ready_before_edge", in_ready, 1'b0);
        @(negedge clk);
        chk("in_ready_first_edge", in_ready, 1'b1);

        // ECB-equivalent with iv = 0
        load_iv(128'h0, 1'b0);
        send_block(PT0, 1'b0, 1'b1, CT0);
        chk("ecb_enc_data", enc_data, PT0);
        drain();

        // Chaining: feeding the previous ciphertext gives a zero cipher input
        send_block(CT0, 1'b0, 1'b0, 128'h0);
        chk("chain_enc_data_zero", enc_data, 128'h0);
        drain();

        // IV XOR with zero plaintext
        load_iv(PT0, 1'b0);
        send_block(128'h0, 1'b0, 1'b1, CT0);
        drain();

        // Backpressure with random input gaps
        load_iv(PT0, 1'b0);
        out_ready = 1'b0;
        send_block(128'h0, 1'b1, 1'b1, CT0);
        wait_out_valid();
        for (int i = 0; i < 5; i++) begin
            chk("bp_out_data", out_data, 32'h3925841d);
            chk("bp_in_ready", in_ready, 1'b0);
            @(negedge clk);
        end
        drain();

        // Abort: two words, then iv_load with a junk word presented alongside
        send_words({$urandom, $urandom, $urandom, $urandom}, 2, 1'b0);
        v = {$urandom, $urandom, $urandom, $urandom};
        load_iv(v, 1'b1);
        pt = {$urandom, $urandom, $urandom, $urandom};
        send_block(pt, 1'b0, 1'b0, 128'h0);
        chk("abort_enc_data", enc_data, pt ^ v);
        drain();

        // Reset during EMIT after word 1
        pt = {$urandom, $urandom, $urandom, $urandom};
        out_ready = 1'b0;
        send_block(pt, 1'b0, 1'b0, 128'h0);
        wait_out_valid();
        out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        chk("pre_rst_words_left", sb.size(), 2);
        #3;
        rst = 1'b1;
        #1;
        chk("rst_emit_out_valid", out_valid, 1'b0);
        chk("rst_emit_busy", busy, 1'b0);
        chk("rst_emit_out_data", out_data, 32'h0);
        chk("rst_emit_enc_data", enc_data, 128'h0);
        sb.delete();
        chain_m = '0;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_rel_in_ready_low", in_ready, 1'b0);
        @(negedge clk);
        chk("rst_rel_in_ready_high", in_ready, 1'b1);
        pt = {$urandom, $urandom, $urandom, $urandom};
        send_block(pt, 1'b0, 1'b0, 128'h0);
        chk("post_rst_chain_zero", enc_data, pt);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
